// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor (ECB/CBC), start->busy/valid handshake, o_cipher held until next completion
module aes_enc_iter #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic [0:127] i_plain,
  input  logic [0:127] i_key,
  input  logic         i_iv_load,
  input  logic [0:127] i_iv,
  output logic         o_busy,
  output logic         o_valid,
  output logic [0:127] o_cipher
);
  localparam int RPC = ROUNDS_PER_CYCLE;
  localparam int N = 10 / RPC;
  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]) ^ rcon, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8 * i -: 8]);
    for (int i = 0; i < 16; i++) t[i] = b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4 * c];
      a1 = t[4 * c + 1];
      a2 = t[4 * c + 2];
      a3 = t[4 * c + 3];
      r[127 - 32 * c -: 32] = (last ? {a0, a1, a2, a3} :
        {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)}) ^ k[127 - 32 * c -: 32];
    end
    return r;
  endfunction
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [127:0] st_q, key_q, chain, chain_in, st0, ks0, fin_s, fin_k;
  logic [7:0] rcon_q, rc0, fin_r;
  logic [3:0] rc;
  logic mode_q, accept, run, done, cbc;
  assign o_busy = state == RUN;
  // the first round group is evaluated in the accept cycle itself, giving latency N
  always_comb begin
    accept = i_start && !o_busy;
    run = o_busy || accept;
    done = run && rc == 4'(N - 1);
    cbc = o_busy ? mode_q : i_mode;
    chain_in = i_iv_load ? i_iv : chain;
    st0 = o_busy ? st_q : i_plain ^ i_key ^ (i_mode ? chain_in : '0);
    ks0 = o_busy ? key_q : i_key;
    rc0 = o_busy ? rcon_q : 8'h01;
  end
  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    logic [127:0] s_in, k_in, s, k;
    logic [7:0] r_in, r;
    if (j == 0) begin : g_src
      assign s_in = st0;
      assign k_in = ks0;
      assign r_in = rc0;
    end else begin : g_chain
      assign s_in = g_rnd[j-1].s;
      assign k_in = g_rnd[j-1].k;
      assign r_in = g_rnd[j-1].r;
    end
    assign k = next_key(k_in, r_in);
    assign r = xt(r_in);
    assign s = aes_round(s_in, k, j == RPC - 1 && rc == 4'(N - 1));
  end
  assign fin_s = g_rnd[RPC-1].s;
  assign fin_k = g_rnd[RPC-1].k;
  assign fin_r = g_rnd[RPC-1].r;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      rc <= '0;
      o_valid <= 1'b0;
      o_cipher <= '0;
      chain <= '0;
      st_q <= '0;
      key_q <= '0;
      rcon_q <= '0;
      mode_q <= 1'b0;
    end else begin
      o_valid <= done;
      if (accept) mode_q <= i_mode;
      if (run) begin
        st_q <= fin_s;
        key_q <= fin_k;
        rcon_q <= fin_r;
      end
      rc <= done ? '0 : run ? rc + 4'd1 : rc;
      state <= run && !done ? RUN : IDLE;
      if (done) o_cipher <= fin_s;
      if (done && cbc) chain <= fin_s;
      else if (!o_busy && i_iv_load) chain <= i_iv;
    end
  end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: directed FIPS-197 / SP800-38A vectors against aes_enc_iter at every rounds-per-cycle setting
module tb_aes_enc_iter;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic clk = 0, rst = 1, start = 0, mode = 0, iv_load = 0;
  logic [0:127] plain = '0, key = '0, iv_d = '0;
  logic busy [4];
  logic valid [4];
  logic [0:127] ciph [4];
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  aes_enc_iter #(.ROUNDS_PER_CYCLE(1)) u1 (.i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .i_plain(plain), .i_key(key), .i_iv_load(iv_load), .i_iv(iv_d), .o_busy(busy[0]), .o_valid(valid[0]), .o_cipher(ciph[0]));
  aes_enc_iter #(.ROUNDS_PER_CYCLE(2)) u2 (.i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .i_plain(plain), .i_key(key), .i_iv_load(iv_load), .i_iv(iv_d), .o_busy(busy[1]), .o_valid(valid[1]), .o_cipher(ciph[1]));
  aes_enc_iter #(.ROUNDS_PER_CYCLE(5)) u5 (.i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .i_plain(plain), .i_key(key), .i_iv_load(iv_load), .i_iv(iv_d), .o_busy(busy[2]), .o_valid(valid[2]), .o_cipher(ciph[2]));
  aes_enc_iter #(.ROUNDS_PER_CYCLE(10)) u10 (.i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .i_plain(plain), .i_key(key), .i_iv_load(iv_load), .i_iv(iv_d), .o_busy(busy[3]), .o_valid(valid[3]), .o_cipher(ciph[3]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [127:0] p, input logic [127:0] k, input logic m, input logic ld,
                     input logic [127:0] iv, output int lat, output logic [127:0] c);
    plain = p;
    key = k;
    mode = m;
    iv_load = ld;
    iv_d = iv;
    start = 1;
    tick();
    start = 0;
    iv_load = 0;
    lat = -1;
    c = '0;
    for (int i = 1; i <= 20; i++) begin
      if (valid[0]) begin
        lat = i;
        c = ciph[0];
        break;
      end
      tick();
    end
  endtask
  initial begin
    int lat, nv;
    int lat4 [4];
    int expn [4];
    logic [127:0] c;
    logic [127:0] c4 [4];
    logic b10;
    expn = '{10, 5, 2, 1};
    tick();
    tick();
    rst = 0;
    chk("rst_busy", 128'(busy[0]), 0);
    chk("rst_valid", 128'(valid[0]), 0);
    chk("rst_cipher", ciph[0], 0);
    chk("rst_chain", u1.chain, 0);
    plain = P1;
    key = K1;
    mode = 0;
    start = 1;
    tick();
    start = 0;
    lat4 = '{-1, -1, -1, -1};
    b10 = 0;
    for (int i = 1; i <= 12; i++) begin
      for (int d = 0; d < 4; d++)
        if (valid[d] && lat4[d] < 0) begin
          lat4[d] = i;
          c4[d] = ciph[d];
        end
      b10 |= busy[3];
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("c1_lat_rpc%0d", 10 / expn[d]), 128'(lat4[d]), 128'(expn[d]));
      chk($sformatf("c1_cipher_rpc%0d", 10 / expn[d]), c4[d], C1);
    end
    chk("rpc10_busy", 128'(b10), 0);
    run(128'h3243f6a8885a308d313198a2e0370734, K2, 0, 0, 0, lat, c);
    chk("b_lat", 128'(lat), 10);
    chk("b_cipher", c, 128'h3925841d02dc09fbdc118597196a0b32);
    run(128'h6bc1bee22e409f96e93d7e117393172a, K2, 1, 1, K1, lat, c);
    chk("cbc1_lat", 128'(lat), 10);
    chk("cbc1_cipher", c, 128'h7649abac8119b246cee98e9b12e9197d);
    chk("cbc1_busy_at_valid", 128'(busy[0]), 0);
    run(128'hae2d8a571e03ac9c9eb76fac45af8e51, K2, 1, 0, 0, lat, c);
    chk("cbc2_gap", 128'(lat), 10);
    chk("cbc2_cipher", c, 128'h5086cb9b507219ee95db113a917678b2);
    chk("cbc2_chain", u1.chain, 128'h5086cb9b507219ee95db113a917678b2);
    run(P1, K1, 0, 0, 0, lat, c);
    chk("ecb_after_cbc", c, C1);
    chk("ecb_chain_kept", u1.chain, 128'h5086cb9b507219ee95db113a917678b2);
    tick();
    plain = P1;
    key = K1;
    mode = 0;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    plain = 128'hdeadbeef_00000000_cafef00d_12345678;
    mode = 1;
    iv_load = 1;
    iv_d = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    start = 1;
    tick();
    start = 0;
    iv_load = 0;
    mode = 0;
    nv = 0;
    c = '0;
    for (int i = 0; i < 17; i++) begin
      if (valid[0]) begin
        nv++;
        c = ciph[0];
      end
      tick();
    end
    chk("busy_one_valid", 128'(nv), 1);
    chk("busy_cipher", c, C1);
    chk("busy_chain", u1.chain, 128'h5086cb9b507219ee95db113a917678b2);
    plain = P1;
    key = K1;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", 128'(busy[0]), 0);
    chk("abort_valid", 128'(valid[0]), 0);
    chk("abort_cipher", ciph[0], 0);
    chk("abort_chain", u1.chain, 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid[0]) nv++;
      tick();
    end
    chk("abort_no_pulse", 128'(nv), 0);
    run(P1, K1, 0, 0, 0, lat, c);
    chk("fresh_lat", 128'(lat), 10);
    chk("fresh_cipher", c, C1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
